// File: rtl/speicher_arbiter_pkg.sv
// Shared types and default widths for the memory-port arbiter.
package speicher_arbiter_pkg;

    localparam int unsigned ADDR_WIDTH_DEFAULT = 32;
    localparam int unsigned DATA_WIDTH_DEFAULT = 32;

    typedef enum logic [2:0] {
        IDLE            = 3'd0,
        BEFEHL          = 3'd1,
        DATEN_LESEN     = 3'd2,
        DATEN_SCHREIBEN = 3'd3,
        FERTIG          = 3'd4
    } zustand_t;

endpackage

// File: rtl/speicher_arbiter_if.sv
// Single memory port: the arbiter drives commands (master), the memory answers (slave).
interface speicher_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = speicher_arbiter_pkg::ADDR_WIDTH_DEFAULT,
    parameter int unsigned DATA_WIDTH = speicher_arbiter_pkg::DATA_WIDTH_DEFAULT
) ();

    logic [ADDR_WIDTH-1:0] MemAdresse;
    logic [DATA_WIDTH-1:0] MemSchreibDaten;
    logic                  MemLesen;
    logic                  MemSchreiben;
    logic                  MemBereit;
    logic [DATA_WIDTH-1:0] MemLeseDaten;

    modport master (
        output MemAdresse, MemSchreibDaten, MemLesen, MemSchreiben,
        input  MemBereit, MemLeseDaten
    );

    modport slave (
        input  MemAdresse, MemSchreibDaten, MemLesen, MemSchreiben,
        output MemBereit, MemLeseDaten
    );

endinterface

// File: rtl/speicher_timeout_zaehler.sv
// Counts busy cycles without acknowledge; flags the cycle in which TIMEOUT is reached.
module speicher_timeout_zaehler #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic Clock,
    input  logic Reset,
    input  logic loeschen,
    input  logic zaehlen,
    output logic abgelaufen_c
);

    generate
        if (TIMEOUT == 0) begin : g_aus
            assign abgelaufen_c = 1'b0;
        end else begin : g_an
            localparam int unsigned ZW = $clog2(TIMEOUT + 1);

            logic [ZW-1:0] zaehler;

            // Saturates at TIMEOUT so a stuck enable cannot wrap around.
            always_ff @(posedge Clock) begin
                if (Reset || loeschen) begin
                    zaehler <= '0;
                end else if (zaehlen && (zaehler != ZW'(TIMEOUT))) begin
                    zaehler <= zaehler + ZW'(1);
                end
            end

            // Lookahead: this un-acknowledged cycle is the TIMEOUT-th one.
            assign abgelaufen_c = zaehlen && (zaehler == ZW'(TIMEOUT - 1));
        end
    endgenerate

endmodule

// File: rtl/speicher_arbiter.sv
// Shares the single memory port between instruction fetch and data load/store,
// one transaction at a time, with completion pulses and a sticky timeout flag.
module speicher_arbiter
    import speicher_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEFAULT,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  LoadBefehlSignal,
    input  logic [ADDR_WIDTH-1:0] BefehlAdresse,
    output logic                  BefehlGeladen,
    output logic [DATA_WIDTH-1:0] Befehl,
    input  logic                  LoadDatenSignal,
    input  logic                  StoreDatenSignal,
    input  logic [ADDR_WIDTH-1:0] DatenAdresse,
    input  logic [DATA_WIDTH-1:0] SchreibDaten,
    output logic                  DatenGeladen,
    output logic                  DatenGespeichert,
    output logic [DATA_WIDTH-1:0] GeladeneDaten,
    output logic                  Belegt,
    output logic                  SpeicherFehler,
    speicher_arbiter_if.master    mem
);

    zustand_t zustand;
    logic     istBusy;
    logic     zeitAbgelaufen;

    assign istBusy = (zustand == BEFEHL) || (zustand == DATEN_LESEN) ||
                     (zustand == DATEN_SCHREIBEN);

    speicher_timeout_zaehler #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .Clock       (Clock),
        .Reset       (Reset),
        .loeschen    (zustand == IDLE),
        .zaehlen     (istBusy && !mem.MemBereit),
        .abgelaufen_c(zeitAbgelaufen)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            zustand              <= IDLE;
            mem.MemAdresse       <= '0;
            mem.MemSchreibDaten  <= '0;
            mem.MemLesen         <= 1'b0;
            mem.MemSchreiben     <= 1'b0;
            BefehlGeladen        <= 1'b0;
            DatenGeladen         <= 1'b0;
            DatenGespeichert     <= 1'b0;
            Befehl               <= '0;
            GeladeneDaten        <= '0;
            Belegt               <= 1'b0;
            SpeicherFehler       <= 1'b0;
        end else begin
            BefehlGeladen    <= 1'b0;
            DatenGeladen     <= 1'b0;
            DatenGespeichert <= 1'b0;

            case (zustand)
                // Fixed priority: store, then load, then fetch.
                IDLE: begin
                    if (StoreDatenSignal) begin
                        zustand             <= DATEN_SCHREIBEN;
                        mem.MemAdresse      <= DatenAdresse;
                        mem.MemSchreibDaten <= SchreibDaten;
                        mem.MemSchreiben    <= 1'b1;
                        Belegt              <= 1'b1;
                    end else if (LoadDatenSignal) begin
                        zustand        <= DATEN_LESEN;
                        mem.MemAdresse <= DatenAdresse;
                        mem.MemLesen   <= 1'b1;
                        Belegt         <= 1'b1;
                    end else if (LoadBefehlSignal) begin
                        zustand        <= BEFEHL;
                        mem.MemAdresse <= BefehlAdresse;
                        mem.MemLesen   <= 1'b1;
                        Belegt         <= 1'b1;
                    end
                end

                // A timed-out transaction still completes, with zero read data.
                BEFEHL, DATEN_LESEN, DATEN_SCHREIBEN: begin
                    if (mem.MemBereit || zeitAbgelaufen) begin
                        zustand          <= FERTIG;
                        mem.MemLesen     <= 1'b0;
                        mem.MemSchreiben <= 1'b0;
                        if (!mem.MemBereit) begin
                            SpeicherFehler <= 1'b1;
                        end
                        case (zustand)
                            BEFEHL: begin
                                Befehl        <= mem.MemBereit ? mem.MemLeseDaten : '0;
                                BefehlGeladen <= 1'b1;
                            end
                            DATEN_LESEN: begin
                                GeladeneDaten <= mem.MemBereit ? mem.MemLeseDaten : '0;
                                DatenGeladen  <= 1'b1;
                            end
                            default: begin
                                DatenGespeichert <= 1'b1;
                            end
                        endcase
                    end
                end

                // Gap cycle so the requester can drop its level request.
                FERTIG: begin
                    zustand <= IDLE;
                    Belegt  <= 1'b0;
                end

                default: begin
                    zustand <= IDLE;
                    Belegt  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/speicher_arbiter.md
Name: speicher_arbiter

Overview:
Shares the processor's single memory port between the instruction-fetch requester and the data load/store requester. Both requesters are the control FSM's level request signals (LoadBefehlSignal, LoadDatenSignal, StoreDatenSignal). The block runs one memory transaction at a time, returns the matching completion pulse (BefehlGeladen, DatenGeladen, DatenGespeichert) and registers the read data. A timeout counter catches a memory that never answers.

Parameters:
ADDR_WIDTH, 32, width of all address ports
DATA_WIDTH, 32, width of all data ports
TIMEOUT, 255, maximum number of cycles to wait for MemBereit; 0 disables the timeout

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  synchronous, active-high reset
LoadBefehlSignal  in  1  instruction fetch request, level, held until BefehlGeladen
BefehlAdresse  in  ADDR_WIDTH  fetch address (PC)
BefehlGeladen  out  1  one-cycle pulse, instruction fetch complete
Befehl  out  DATA_WIDTH  registered fetched instruction
LoadDatenSignal  in  1  data load request, level, held until DatenGeladen
StoreDatenSignal  in  1  data store request, level, held until DatenGespeichert
DatenAdresse  in  ADDR_WIDTH  load/store address
SchreibDaten  in  DATA_WIDTH  store data
DatenGeladen  out  1  one-cycle pulse, load complete
DatenGespeichert  out  1  one-cycle pulse, store complete
GeladeneDaten  out  DATA_WIDTH  registered load data
MemAdresse  out  ADDR_WIDTH  memory address, registered
MemSchreibDaten  out  DATA_WIDTH  memory write data, registered
MemLesen  out  1  memory read command, held until MemBereit
MemSchreiben  out  1  memory write command, held until MemBereit
MemBereit  in  1  memory acknowledge; completes the current command in the same cycle
MemLeseDaten  in  DATA_WIDTH  read data, valid while MemBereit=1
Belegt  out  1  high in every state except IDLE
SpeicherFehler  out  1  sticky timeout flag

Behaviour:
- Clock and reset: one clock (Clock); Reset is synchronous and active-high.
- State machine states: IDLE, BEFEHL, DATEN_LESEN, DATEN_SCHREIBEN, FERTIG.
- Reset values: state IDLE; all Mem* outputs 0; all completion pulses 0; Befehl 0; GeladeneDaten 0; SpeicherFehler 0; timeout counter 0.
- IDLE arbitration, evaluated each cycle, fixed priority:
  - StoreDatenSignal -> DATEN_SCHREIBEN
  - else LoadDatenSignal -> DATEN_LESEN
  - else LoadBefehlSignal -> BEFEHL
  - else stay in IDLE
- Grant edge: the granted address is latched into MemAdresse; for a store, SchreibDaten is latched into MemSchreibDaten. MemLesen or MemSchreiben is high from the next cycle.
- Busy states:
  - The command stays asserted with address and data stable until MemBereit=1.
  - On the edge where MemBereit=1: MemLeseDaten is captured into Befehl (BEFEHL) or GeladeneDaten (DATEN_LESEN), then state -> FERTIG.
- FERTIG:
  - Exactly one cycle; commands are low.
  - Exactly one completion pulse, matching the granted requester, is high.
  - Next state is IDLE unconditionally. This gap cycle lets the requester drop its level request, so no duplicate transaction starts.
- Latency: request seen in IDLE at cycle 0, MemBereit at cycle k (k >= 1) -> completion pulse at cycle k+1. Minimum request-to-pulse latency is 2 cycles.
- Unused read register holds its value; Befehl and GeladeneDaten change only on their own completion.
- Timeout (TIMEOUT>0):
  - The counter clears on grant and increments every busy cycle without MemBereit.
  - When it reaches TIMEOUT: drop the command, set SpeicherFehler, go to FERTIG and pulse the completion anyway.
  - The read register loads 0 on a timed-out read.
  - SpeicherFehler is cleared only by Reset.
- Requests that drop while busy are ignored; the transaction completes and the pulse is still generated.
- Load and store both high at once is illegal from the control FSM; store wins.
- Reset mid-transaction: IDLE after the edge, commands low, no completion pulse, all registers back to reset values.
- MemBereit while in IDLE or FERTIG is ignored.

Decomposition:
- Shared package holds: state encoding constants (IDLE, BEFEHL, DATEN_LESEN, DATEN_SCHREIBEN, FERTIG) and default ADDR_WIDTH/DATA_WIDTH constants.
- One sub-module, speicher_timeout_zaehler: clear, enable and TIMEOUT parameter in; expiry out. This keeps the counter width rule (clog2(TIMEOUT+1)) out of the FSM.

Test Plan:
- Fetch, LoadBefehlSignal=1, BefehlAdresse=0x100, MemBereit at cycle 3 with MemLeseDaten=0xDEADBEEF -> MemLesen high cycles 1-3 with MemAdresse=0x100; BefehlGeladen pulse at cycle 4; Befehl=0xDEADBEEF; no second MemLesen while the request falls.
- Store, StoreDatenSignal=1, DatenAdresse=0x2004, SchreibDaten=0x12345678, immediate MemBereit -> MemSchreiben for exactly 1 cycle with MemSchreibDaten=0x12345678; DatenGespeichert at cycle 2; GeladeneDaten unchanged.
- Simultaneous LoadBefehlSignal and LoadDatenSignal -> data read is served first with DatenGeladen; after the gap cycle, fetch is served; Befehl and GeladeneDaten each hold their own data.
- Timeout, TIMEOUT=4, MemBereit never asserted -> command drops after 4 busy cycles; pulse one cycle later; SpeicherFehler=1 and stays 1 across later good transactions until Reset.
- Reset asserted in cycle 2 of a pending load -> next cycle MemLesen=0, Belegt=0, no DatenGeladen; a late MemBereit is ignored.
- Back-to-back fetch/load/store/fetch sequence following the control FSM's order -> exactly one completion pulse per request; zero overlapping commands; every pulse is 1 cycle wide.
